// File: rtl/servant_uart_rx.sv
// Wishbone-attached 8N1 UART receiver for the servant SoC.
// Oversamples i_rx with a programmable divisor and holds one received byte.
module servant_uart_rx #(
  parameter int DIVISOR = 139
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  input  logic        i_rx,
  output logic        o_irq
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta, rx_s, rx_q;

  logic [7:0]       data;
  logic             valid, ferr, ovr;
  logic             ack;
  logic [31:0]      rdt;

  logic             acc, rd_clr, ferr_clr, ovr_clr;
  logic             stop_tick, byte_done, frame_err;
  logic             unused_dat;

  // Only bits 9 and 10 of the write data carry meaning.
  assign unused_dat = ^{i_wb_dat[31:11], i_wb_dat[8:0]};

  assign acc      = i_wb_cyc & ~ack;
  assign rd_clr   = acc & ~i_wb_we;
  assign ferr_clr = acc & i_wb_we & i_wb_dat[9];
  assign ovr_clr  = acc & i_wb_we & i_wb_dat[10];

  assign stop_tick = (state == STOP) && (cnt == BIT_LAST);
  assign byte_done = stop_tick & rx_s;
  assign frame_err = stop_tick & ~rx_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s && rx_q) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Return at mid stop bit so a following start edge is not missed.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Status flags: a set on the same edge as its clear wins.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
      ack   <= 1'b0;
      rdt   <= '0;
    end else begin
      ack <= acc;
      if (acc) rdt <= {21'b0, ovr, ferr, valid, data};
      if (byte_done) data <= shift;
      valid <= byte_done | (valid & ~rd_clr);
      ferr  <= frame_err | (ferr & ~ferr_clr);
      ovr   <= (byte_done & valid & ~rd_clr) | (ovr & ~ovr_clr);
    end
  end

  assign o_wb_ack = ack;
  assign o_wb_rdt = rdt;
  assign o_irq    = valid;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Self-checking bench for servant_uart_rx: directed protocol cases followed by
// random frames checked against a frame-level model of the status register.
module tb_servant_uart_rx;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [31:0] dat = '0;
  logic        rx = 1'b1;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;

  int          n_checks = 0;
  int          n_fails = 0;
  int          irq_edge;
  logic [31:0] col_rdt;

  logic [7:0]  m_data;
  logic        m_valid, m_ferr, m_ovr;

  always #5 clk = ~clk;

  servant_uart_rx #(.DIVISOR(D)) dut (
    .i_wb_clk  (clk),
    .i_wb_rst_n(rst_n),
    .i_wb_cyc  (cyc),
    .i_wb_we   (we),
    .i_wb_dat  (dat),
    .o_wb_rdt  (rdt),
    .o_wb_ack  (ack),
    .i_rx      (rx),
    .o_irq     (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; edge 1 is the first rising edge after the start bit falls.
  // If cyc_edge > 0, a read cycle is raised after that edge so it is acked one edge later.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pre, input int cyc_edge);
    logic [9:0] bits;
    int         e;
    bits     = {stop, b, 1'b0};
    e        = 0;
    irq_edge = -1;
    rx       = 1'b1;
    if (pre > 0) tick(pre);
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      for (int j = 0; j < D; j++) begin
        @(posedge clk);
        #1;
        e++;
        if (irq && irq_edge < 0) irq_edge = e;
        if (e == cyc_edge) begin
          cyc = 1'b1;
          we  = 1'b0;
        end
        if (cyc_edge > 0 && e == cyc_edge + 1) begin
          check("collide_ack", {31'b0, ack}, 32'd1);
          col_rdt = rdt;
          cyc     = 1'b0;
        end
      end
    end
  endtask

  task automatic wb_read(input string tag, input logic [31:0] exp);
    cyc = 1'b1;
    we  = 1'b0;
    tick(1);
    check({tag, "_ack"}, {31'b0, ack}, 32'd1);
    check(tag, rdt, exp);
    cyc = 1'b0;
    tick(1);
  endtask

  task automatic wb_write(input logic [31:0] d);
    cyc = 1'b1;
    we  = 1'b1;
    dat = d;
    tick(1);
    check("write_ack", {31'b0, ack}, 32'd1);
    cyc = 1'b0;
    we  = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [7:0]  rb;
    logic        rstop;
    logic [31:0] w;

    // Reset state
    tick(3);
    check("reset_rdt", rdt, 32'h0);
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Glitch: line low for three cycles only
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * D);
    check("glitch_irq", {31'b0, irq}, 32'd0);
    wb_read("glitch_read", 32'h0);

    // Framing error, line then held low (break) for 100 bit times
    send_frame(8'h3C, 1'b0, 2, -1);
    tick(100 * D);
    check("break_irq", {31'b0, irq}, 32'd0);
    wb_read("ferr_read", 32'h0000_0200);
    wb_write(32'h0000_0200);
    wb_read("ferr_clr_read", 32'h0);
    rx = 1'b1;
    tick(4);

    // Single byte and valid timing
    send_frame(8'hA5, 1'b1, 2, -1);
    check("irq_rise_edge", (irq_edge >= 154 && irq_edge <= 156) ? 32'd155 : irq_edge, 32'd155);
    check("a5_irq", {31'b0, irq}, 32'd1);
    wb_read("a5_read", 32'h0000_01A5);
    check("a5_irq_clr", {31'b0, irq}, 32'd0);
    wb_read("a5_reread", 32'h0000_00A5);

    // Overrun on back-to-back frames
    send_frame(8'h11, 1'b1, 2, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    wb_read("ovr_read", 32'h0000_0522);
    wb_write(32'h0000_0400);
    wb_read("ovr_clr_read", 32'h0000_0022);

    // Read-clear colliding with the stop sample of the next byte
    send_frame(8'h55, 1'b1, 2, -1);
    check("collide_first_irq", {31'b0, irq}, 32'd1);
    send_frame(8'h7E, 1'b1, 0, 154);
    check("collide_rdt", col_rdt, 32'h0000_0155);
    check("collide_irq", {31'b0, irq}, 32'd1);
    wb_read("collide_next", 32'h0000_017E);

    // Reset during data bit 4 of 0xFF, with a byte pending beforehand
    send_frame(8'h5A, 1'b1, 2, -1);
    wb_read("pre_rst_read", 32'h0000_015A);
    send_frame(8'h33, 1'b1, 2, -1);
    rx = 1'b0;
    tick(D);
    rx = 1'b1;
    tick(4 * D + 8);
    rst_n = 1'b0;
    #2;
    check("midrst_rdt", rdt, 32'h0);
    check("midrst_ack", {31'b0, ack}, 32'd0);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    send_frame(8'h81, 1'b1, 2, -1);
    wb_read("after_rst_read", 32'h0000_0181);

    // Random frames against the frame-level model
    m_data  = 8'h81;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(3) != 0);
      send_frame(rb, rstop, 3, -1);
      if (rstop) begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = rb;
        m_valid = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
      check("rnd_irq", {31'b0, irq}, {31'b0, m_valid});
      if ($urandom_range(1) == 1) begin
        wb_read("rnd_read", {21'b0, m_ovr, m_ferr, m_valid, m_data});
        m_valid = 1'b0;
      end
      if ($urandom_range(2) == 0) begin
        w = $urandom;
        wb_write(w);
        if (w[9])  m_ferr = 1'b0;
        if (w[10]) m_ovr  = 1'b0;
      end
    end
    rx = 1'b1;
    tick(3);
    wb_read("rnd_final", {21'b0, m_ovr, m_ferr, m_valid, m_data});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
